e1_tx_ts_sched: RTL and testbench



---
 rtl/e1_tx_ts_sched.sv | 95 +++++++++
 tb/tb_e1_tx_ts_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/e1_tx_ts_sched.sv
// E1 transmit timeslot/frame scheduler: counts bits, slots and frames in the clk2 domain
// and builds each outgoing byte (FAS/NFAS, MFAS, payload or IDLE) for the serializer.
module e1_tx_ts_sched #(
   parameter logic [6:0] FASW = 7'b0011011,
   parameter logic [7:0] IDLE = 8'hFF
) (
   input  logic       clk2,
   input  logic       rst,
   input  logic       en,
   input  logic       cas,
   input  logic       rai,
   input  logic       rmai,
   input  logic [4:0] sa,
   input  logic       ais,
   output logic       pld_req,
   output logic [4:0] pld_ts,
   input  logic [7:0] pld_data,
   input  logic       pld_vld,
   output logic       ld,
   output logic [7:0] txbyte,
   output logic [4:0] txts,
   output logic [3:0] txfrm,
   output logic       mfs,
   output logic       urun
);

   logic [2:0] bitcnt;
   logic [4:0] ts;
   logic [3:0] frm;
   logic       ld_r;
   logic       mfs_r;
   logic       urun_r;
   logic       pay;
   logic [7:0] nxt_byte;
   logic       nxt_urun;

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      pay      = (ts != 5'd0) && !((ts == 5'd16) && (frm == 4'd0) && cas);
      nxt_byte = IDLE;
      nxt_urun = 1'b0;
      if (ais)
         nxt_byte = IDLE;
      else if ((ts == 5'd0) && !frm[0])
         nxt_byte = {1'b1, FASW};
      else if (ts == 5'd0)
         nxt_byte = {2'b11, rai, sa};
      else if (!pay)
         nxt_byte = {4'b0000, 1'b1, rmai, 2'b11};
      else if (pld_vld)
         nxt_byte = pld_data;
      else
         nxt_urun = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk2 or negedge rst) begin
      if (!rst) begin
         bitcnt <= 3'd0;
         ts     <= 5'd0;
         frm    <= 4'd0;
         ld_r   <= 1'b0;
         mfs_r  <= 1'b0;
         urun_r <= 1'b0;
         txbyte <= IDLE;
         txts   <= 5'd0;
         txfrm  <= 4'd0;
      end else if (en) begin
         bitcnt <= bitcnt + 3'd1;
         ld_r   <= 1'b0;
         mfs_r  <= 1'b0;
         urun_r <= 1'b0;
         // Last bit of the slot: commit the byte and step to the next slot.
         if (bitcnt == 3'd7) begin
            ld_r   <= 1'b1;
            txbyte <= nxt_byte;
            txts   <= ts;
            txfrm  <= frm;
            mfs_r  <= (ts == 5'd0) && (frm == 4'd0);
            urun_r <= nxt_urun;
            ts     <= ts + 5'd1;
            if (ts == 5'd31)
               frm <= frm + 4'd1;
         end
      end
   end

   // Strobes are masked while disabled; a held ld_r is delivered once counting resumes.
   assign ld      = ld_r & en;
   assign mfs     = mfs_r & en;
   assign urun    = urun_r & en;
   assign pld_req = en && (bitcnt == 3'd6) && pay && !ais;
   assign pld_ts  = ts;

endmodule

// File: tb/tb_e1_tx_ts_sched.sv
// Directed self-checking bench for e1_tx_ts_sched: frame build, CAS, underrun, AIS,
// enable stalls and mid-operation reset.
module tb_e1_tx_ts_sched;

   logic       clk2;
   logic       rst;
   logic       en;
   logic       cas;
   logic       rai;
   logic       rmai;
   logic [4:0] sa;
   logic       ais;
   logic       pld_req;
   logic [4:0] pld_ts;
   logic [7:0] pld_data;
   logic       pld_vld;
   logic       ld;
   logic [7:0] txbyte;
   logic [4:0] txts;
   logic [3:0] txfrm;
   logic       mfs;
   logic       urun;

   e1_tx_ts_sched dut (
      .clk2(clk2), .rst(rst), .en(en), .cas(cas), .rai(rai), .rmai(rmai), .sa(sa),
      .ais(ais), .pld_req(pld_req), .pld_ts(pld_ts), .pld_data(pld_data),
      .pld_vld(pld_vld), .ld(ld), .txbyte(txbyte), .txts(txts), .txfrm(txfrm),
      .mfs(mfs), .urun(urun)
   );

   initial clk2 = 1'b0;
   always #5 clk2 = ~clk2;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int ld_cyc = 0;
   int prev_ld_cyc = 0;
   int ld_total = 0;
   int req_cnt = 0;
   int req16_cnt = 0;
   int urun_cnt = 0;
   int mfs_at = 0;
   int snap = 0;
   logic       ld_seen;
   logic       drop_en;
   logic [7:0] cap_byte;
   logic [4:0] cap_ts;
   logic [3:0] cap_frm;
   logic       cap_mfs;
   logic       cap_urun;
   logic [4:0] e_ts;
   logic [3:0] e_frm;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Samples outputs mid-cycle, then advances one clock and answers the payload port.
   task automatic tick();
      #3;
      if (ld) begin
         ld_seen     = 1'b1;
         cap_byte    = txbyte;
         cap_ts      = txts;
         cap_frm     = txfrm;
         cap_mfs     = mfs;
         cap_urun    = urun;
         prev_ld_cyc = ld_cyc;
         ld_cyc      = cyc;
         ld_total++;
      end
      if (urun) urun_cnt++;
      if (pld_req) begin
         req_cnt++;
         if (pld_ts == 5'd16) req16_cnt++;
      end
      @(posedge clk2);
      #1;
      cyc++;
      pld_data = {3'b000, pld_ts};
      pld_vld  = !(drop_en && (pld_ts == 5'd5));
   endtask

   task automatic wait_ld();
      int n = 0;
      ld_seen = 1'b0;
      while (!ld_seen && n < 40) begin
         tick();
         n++;
      end
      if (!ld_seen) check("ld_timeout", 32'd0, 32'd1);
   endtask

   function automatic logic [7:0] model(input logic [4:0] t, input logic [3:0] f);
      if (t == 5'd0 && !f[0]) return 8'h9B;
      if (t == 5'd0) return {2'b11, rai, sa};
      if (t == 5'd16 && f == 4'd0 && cas) return {4'b0000, 1'b1, rmai, 2'b11};
      return {3'b000, t};
   endfunction

   task automatic expect_ld(input string tag, input logic [7:0] b, input logic u, input int gap);
      wait_ld();
      check({tag, "_byte"}, cap_byte, b);
      check({tag, "_ts"}, cap_ts, e_ts);
      check({tag, "_frm"}, cap_frm, e_frm);
      check({tag, "_mfs"}, cap_mfs, (e_ts == 5'd0) && (e_frm == 4'd0));
      check({tag, "_urun"}, cap_urun, u);
      if (gap != 0) check({tag, "_gap"}, ld_cyc - prev_ld_cyc, gap);
      e_ts = e_ts + 5'd1;
      if (e_ts == 5'd0) e_frm = e_frm + 4'd1;
   endtask

   task automatic run_to(input logic [4:0] t, input logic [3:0] f);
      while (!(e_ts == t && e_frm == f))
         expect_ld("run", model(e_ts, e_frm), 1'b0, 8);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; en = 1'b1; cas = 1'b0; rai = 1'b0; rmai = 1'b0; sa = 5'd0; ais = 1'b0;
      pld_data = 8'd0; pld_vld = 1'b1; drop_en = 1'b0;
      e_ts = 5'd0; e_frm = 4'd0;
      @(posedge clk2);
      #1;
      tick();
      tick();

      // Reset state
      check("rst_ld", ld, 1'b0);
      check("rst_req", pld_req, 1'b0);
      check("rst_pld_ts", pld_ts, 5'd0);
      check("rst_txbyte", txbyte, 8'hFF);
      check("rst_txts", txts, 5'd0);
      check("rst_txfrm", txfrm, 4'd0);
      check("rst_mfs", mfs, 1'b0);
      check("rst_urun", urun, 1'b0);

      // 1: first frame, payload = slot number
      rst = 1'b1; cyc = 1; ld_total = 0; req_cnt = 0;
      expect_ld("t1_fas", 8'h9B, 1'b0, 0);
      check("t1_first_ld_cyc", ld_cyc, 9);
      mfs_at = ld_total;
      for (int i = 1; i < 32; i++) expect_ld("t1", 8'(i), 1'b0, 8);
      check("t1_req_per_frame", req_cnt, 31);

      // 2: NFAS with remote alarm and Sa bits
      rai = 1'b1; sa = 5'b10101;
      expect_ld("t2_nfas", 8'hF5, 1'b0, 8);
      run_to(5'd0, 4'd2);
      expect_ld("t2_fas", 8'h9B, 1'b0, 8);

      // 3: CAS multiframe
      cas = 1'b1; rmai = 1'b1;
      run_to(5'd0, 4'd0);
      expect_ld("t3_mf_start", 8'h9B, 1'b0, 8);
      check("t3_mfs_period", ld_total - mfs_at, 512);
      req16_cnt = 0;
      run_to(5'd16, 4'd0);
      expect_ld("t3_mfas", 8'h0F, 1'b0, 8);
      check("t3_no_req16", req16_cnt, 0);
      run_to(5'd16, 4'd1);
      expect_ld("t3_ts16_pld", 8'h10, 1'b0, 8);
      check("t3_req16", req16_cnt, 1);

      // 4: missing payload byte in TS5
      run_to(5'd5, 4'd2);
      snap = urun_cnt;
      drop_en = 1'b1;
      expect_ld("t4_urun", 8'hFF, 1'b1, 8);
      drop_en = 1'b0;
      expect_ld("t4_ts6", 8'h06, 1'b0, 8);
      check("t4_urun_once", urun_cnt - snap, 1);

      // 5: AIS raised at bitcnt 3 of TS7
      tick();
      tick();
      ais = 1'b1; req_cnt = 0;
      expect_ld("t5_ais_ts7", 8'hFF, 1'b0, 8);
      while (!(e_ts == 5'd1 && e_frm == 4'd3)) expect_ld("t5_ais", 8'hFF, 1'b0, 8);
      check("t5_no_req", req_cnt, 0);
      ais = 1'b0;
      run_to(5'd0, 4'd4);
      expect_ld("t5_fas", 8'h9B, 1'b0, 8);
      run_to(5'd0, 4'd5);
      expect_ld("t5_nfas", 8'hF5, 1'b0, 8);

      // 6a: enable dropped for 5 cycles at bitcnt 4
      tick();
      tick();
      tick();
      en = 1'b0;
      repeat (5) tick();
      en = 1'b1;
      expect_ld("t6_stretch", 8'h01, 1'b0, 13);

      // 6b: enable dropped during the load cycle itself
      repeat (7) tick();
      snap = ld_total;
      en = 1'b0;
      tick();
      tick();
      check("t6_ld_gated", ld_total - snap, 0);
      en = 1'b1;
      expect_ld("t6_ld_held", 8'h02, 1'b0, 10);
      expect_ld("t6_after", 8'h03, 1'b0, 8);

      // 6c: asynchronous reset at bitcnt 2 of TS20
      run_to(5'd20, 4'd5);
      tick();
      rst = 1'b0;
      #1;
      check("t6_arst_txbyte", txbyte, 8'hFF);
      check("t6_arst_txts", txts, 5'd0);
      check("t6_arst_txfrm", txfrm, 4'd0);
      check("t6_arst_ld", ld, 1'b0);
      check("t6_arst_req", pld_req, 1'b0);
      check("t6_arst_pld_ts", pld_ts, 5'd0);
      tick();
      rst = 1'b1; cyc = 1; e_ts = 5'd0; e_frm = 4'd0;
      check("t6_rst_idle", txbyte, 8'hFF);
      expect_ld("t6_rst_fas", 8'h9B, 1'b0, 0);
      check("t6_rst_ld_cyc", ld_cyc, 9);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
